// File: rtl/idexreg_if.sv
`default_nettype none
// ============================================================================
//  Module      : idexreg_if
//  Description : ID->EX pipeline-register bus. Bundles the upstream (ID)
//                handshake and decoded payload, the downstream (EX)
//                handshake and registered payload, flush and hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface idexreg_if #(
    parameter int DW = 32
);
    // Control from the pipeline
    logic          flush;
    logic          hazard;

    // Upstream (ID) side
    logic          in_valid;
    logic          in_ready;
    logic          alualtsrcin;
    logic [1:0]    alusrcin;
    logic [1:0]    regdstin;
    logic [2:0]    aluopin;
    logic          memreadin;
    logic          regwritein;
    logic [4:0]    rsin;
    logic [4:0]    rtin;
    logic [4:0]    rdin;
    logic [DW-1:0] rsdatain;
    logic [DW-1:0] rtdatain;
    logic [DW-1:0] immin;

    // Downstream (EX) side
    logic          out_valid;
    logic          out_ready;
    logic          alualtsrcout;
    logic [1:0]    alusrcout;
    logic [1:0]    regdstout;
    logic [2:0]    aluopout;
    logic          memreadout;
    logic          regwriteout;
    logic [4:0]    rsout;
    logic [4:0]    rtout;
    logic [4:0]    rdout;
    logic [DW-1:0] rsdataout;
    logic [DW-1:0] rtdataout;
    logic [DW-1:0] immout;

    // The pipeline stage itself
    modport slave (
        input  flush, in_valid, alualtsrcin, alusrcin, regdstin, aluopin,
               memreadin, regwritein, rsin, rtin, rdin, rsdatain, rtdatain,
               immin, out_ready,
        output in_ready, hazard, out_valid, alualtsrcout, alusrcout,
               regdstout, aluopout, memreadout, regwriteout, rsout, rtout,
               rdout, rsdataout, rtdataout, immout
    );

    // The surrounding pipeline (ID producer, EX consumer)
    modport master (
        output flush, in_valid, alualtsrcin, alusrcin, regdstin, aluopin,
               memreadin, regwritein, rsin, rtin, rdin, rsdatain, rtdatain,
               immin, out_ready,
        input  in_ready, hazard, out_valid, alualtsrcout, alusrcout,
               regdstout, aluopout, memreadout, regwriteout, rsout, rtout,
               rdout, rsdataout, rtdataout, immout
    );
endinterface
`default_nettype wire

// File: rtl/idexreg.sv
`default_nettype none
// ============================================================================
//  Module      : idexreg
//  Description : Decode/Execute pipeline register. Two-entry skid buffer
//                (output register + skid register) with valid/ready
//                handshakes, load-use bubble insertion and synchronous
//                flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module idexreg #(
    parameter int DW         = 32,
    parameter int LU_BUBBLES = 1
) (
    input  var logic   clk,
    input  var logic   rst_n,
    idexreg_if.slave   bus
);

    localparam logic [1:0] c_LU_BUBBLES = 2'(LU_BUBBLES);

    typedef struct packed {
        logic          alualtsrc;
        logic [1:0]    alusrc;
        logic [1:0]    regdst;
        logic [2:0]    aluop;
        logic          memread;
        logic          regwrite;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [DW-1:0] rsdata;
        logic [DW-1:0] rtdata;
        logic [DW-1:0] imm;
    } entry_t;

    // A held load whose destination is read by the instruction in ID.
    // Register 0 is hard-wired and never creates a dependency.
    function automatic logic f_match(input logic       vld,
                                     input logic       memread,
                                     input logic [4:0] rt,
                                     input logic [4:0] rs_in,
                                     input logic [4:0] rt_in);
        return vld & memread & (rt != 5'd0) & ((rt == rs_in) | (rt == rt_in));
    endfunction

    entry_t     out_q,       out_d;
    entry_t     skid_q,      skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic [1:0] ld_cnt_q,    ld_cnt_d;
    logic [4:0] ld_rt_q,     ld_rt_d;

    entry_t     w_in_entry;
    logic       w_hazard;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_xfer;

    // Pack the decoded ID payload into one entry
    always_comb begin
        w_in_entry           = '0;
        w_in_entry.alualtsrc = bus.alualtsrcin;
        w_in_entry.alusrc    = bus.alusrcin;
        w_in_entry.regdst    = bus.regdstin;
        w_in_entry.aluop     = bus.aluopin;
        w_in_entry.memread   = bus.memreadin;
        w_in_entry.regwrite  = bus.regwritein;
        w_in_entry.rs        = bus.rsin;
        w_in_entry.rt        = bus.rtin;
        w_in_entry.rd        = bus.rdin;
        w_in_entry.rsdata    = bus.rsdatain;
        w_in_entry.rtdata    = bus.rtdatain;
        w_in_entry.imm       = bus.immin;
    end

    // Load-use detection against both held entries and the bubble window
    always_comb begin
        w_hazard   = bus.in_valid &
                     ( f_match(out_valid_q, out_q.memread, out_q.rt, bus.rsin, bus.rtin)
                     | f_match(skid_valid_q, skid_q.memread, skid_q.rt, bus.rsin, bus.rtin)
                     | f_match(ld_cnt_q != 2'd0, 1'b1, ld_rt_q, bus.rsin, bus.rtin) );
        w_in_ready = ~skid_valid_q & ~w_hazard & ~bus.flush;
        w_accept   = bus.in_valid & w_in_ready;
        w_xfer     = out_valid_q & bus.out_ready;
    end

    // Next state: output/skid movement, bubble counter, flush override
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        ld_cnt_d     = ld_cnt_q;
        ld_rt_d      = ld_rt_q;

        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            ld_cnt_d     = 2'd0;
        end else begin
            if (!out_valid_q || bus.out_ready) begin
                // Output register is free this edge; skid drains first
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (w_accept) begin
                    out_d        = w_in_entry;
                    out_valid_d  = 1'b1;
                end else begin
                    out_valid_d  = 1'b0;
                end
            end else if (w_accept) begin
                // EX stalled while ID handed over an instruction: park it
                skid_d       = w_in_entry;
                skid_valid_d = 1'b1;
            end

            if (w_xfer && out_q.memread) begin
                ld_rt_d  = out_q.rt;
                ld_cnt_d = c_LU_BUBBLES;
            end else if (ld_cnt_q != 2'd0) begin
                ld_cnt_d = 2'(ld_cnt_q - 2'd1);
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ld_cnt_q     <= 2'd0;
            ld_rt_q      <= 5'd0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ld_cnt_q     <= ld_cnt_d;
            ld_rt_q      <= ld_rt_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.hazard       = w_hazard;
    assign bus.out_valid    = out_valid_q;
    assign bus.alualtsrcout = out_q.alualtsrc;
    assign bus.alusrcout    = out_q.alusrc;
    assign bus.regdstout    = out_q.regdst;
    assign bus.aluopout     = out_q.aluop;
    assign bus.memreadout   = out_q.memread;
    assign bus.regwriteout  = out_q.regwrite;
    assign bus.rsout        = out_q.rs;
    assign bus.rtout        = out_q.rt;
    assign bus.rdout        = out_q.rd;
    assign bus.rsdataout    = out_q.rsdata;
    assign bus.rtdataout    = out_q.rtdata;
    assign bus.immout       = out_q.imm;

endmodule
`default_nettype wire

// File: tb/tb_idexreg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idexreg
//  Description : Directed self-checking bench for idexreg with an
//                in-order scoreboard of accepted instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idexreg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [120:0] sb_q[$];

    always #5 clk = ~clk;

    idexreg_if #(.DW(32)) bus ();

    idexreg #(.DW(32), .LU_BUBBLES(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [120:0] w_obs = {bus.alualtsrcout, bus.alusrcout, bus.regdstout, bus.aluopout,
                          bus.memreadout, bus.regwriteout, bus.rsout, bus.rtout, bus.rdout,
                          bus.rsdataout, bus.rtdataout, bus.immout};
    wire [120:0] w_drv = {bus.alualtsrcin, bus.alusrcin, bus.regdstin, bus.aluopin,
                          bus.memreadin, bus.regwritein, bus.rsin, bus.rtin, bus.rdin,
                          bus.rsdatain, bus.rtdatain, bus.immin};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on transfer (before push), clear on flush, push on accept
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) chk("sb_payload", 128'(w_obs), 128'(sb_q.pop_front()));
            end
            if (bus.flush) sb_q.delete();
            else if (bus.in_valid && bus.in_ready) sb_q.push_back(w_drv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic mr,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] imm);
        bus.in_valid    = v;
        bus.aluopin     = op;
        bus.memreadin   = mr;
        bus.rsin        = rs;
        bus.rtin        = rt;
        bus.rdin        = rd;
        bus.immin       = imm;
        bus.alualtsrcin = imm[0];
        bus.alusrcin    = imm[2:1];
        bus.regdstin    = imm[4:3];
        bus.regwritein  = 1'b1;
        bus.rsdatain    = {imm[15:0], 16'hA5A5};
        bus.rtdatain    = {16'h5A5A, imm[15:0]};
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

        // ---------------- reset state
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_immout",    bus.immout, 32'd0);
        chk("rst_in_ready",  bus.in_ready, 1'b1);
        #20 rst_n = 1'b1;

        // ---------------- 1: streaming at one per cycle
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'h10 + i);
            #2;
            chk("s1_in_ready", bus.in_ready, 1'b1);
            chk("s1_hazard",   bus.hazard, 1'b0);
            chk("s1_out_valid", bus.out_valid, (i != 0));
            if (i != 0) chk("s1_immout", bus.immout, 32'h10 + i - 1);
            tick();
        end
        drive(1'b0, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0);
        #2 chk("s1_last_imm", bus.immout, 32'h13);
        tick();
        chk("s1_drained", bus.out_valid, 1'b0);

        // ---------------- 2: stall fills skid, third is refused
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b0, 5'd1, 5'd2, 5'd4, 32'h20);
        #2 chk("s2_acc1", bus.in_ready, 1'b1);
        tick();
        drive(1'b1, 3'b001, 1'b0, 5'd1, 5'd2, 5'd4, 32'h21);
        #2 chk("s2_acc2", bus.in_ready, 1'b1);
        tick();
        drive(1'b1, 3'b001, 1'b0, 5'd1, 5'd2, 5'd4, 32'h22);
        #2 chk("s2_full", bus.in_ready, 1'b0);
        chk("s2_hold_imm", bus.immout, 32'h20);
        tick();
        chk("s2_still_full", bus.in_ready, 1'b0);
        chk("s2_stable_imm", bus.immout, 32'h20);
        bus.out_ready = 1'b1;
        tick();
        chk("s2_skid_drain", bus.immout, 32'h21);
        chk("s2_reopen", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("s2_third", bus.immout, 32'h22);
        tick();
        chk("s2_empty", bus.out_valid, 1'b0);
        chk("s2_sb_empty", 128'(sb_q.size()), 128'd0);

        // ---------------- 3: load-use bubble, then rt=0 load
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd5, 5'd0, 32'h30);
        #2 chk("s3_load_nohaz", bus.hazard, 1'b0);
        tick();
        drive(1'b1, 3'b010, 1'b0, 5'd5, 5'd6, 5'd7, 32'h31);
        #2 chk("s3_haz_held", bus.hazard, 1'b1);
        chk("s3_ready_held", bus.in_ready, 1'b0);
        tick();
        chk("s3_haz_bubble", bus.hazard, 1'b1);
        chk("s3_ready_bubble", bus.in_ready, 1'b0);
        chk("s3_bubble_empty", bus.out_valid, 1'b0);
        tick();
        chk("s3_haz_clear", bus.hazard, 1'b0);
        chk("s3_ready_clear", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("s3_add_out", bus.immout, 32'h31);
        tick();
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 32'h32);
        tick();
        drive(1'b1, 3'b010, 1'b0, 5'd0, 5'd0, 5'd9, 32'h33);
        #2 chk("s3_r0_out_nohaz", bus.hazard, 1'b0);
        chk("s3_r0_ready", bus.in_ready, 1'b1);
        tick();
        drive(1'b1, 3'b010, 1'b0, 5'd0, 5'd0, 5'd9, 32'h34);
        #2 chk("s3_r0_ld_nohaz", bus.hazard, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();

        // ---------------- 6: back-to-back loads reload the counter
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd7, 5'd0, 32'h40);
        tick();
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd8, 5'd0, 32'h41);
        #2 chk("s6_ld8_nohaz", bus.hazard, 1'b0);
        tick();
        drive(1'b1, 3'b010, 1'b0, 5'd7, 5'd9, 5'd10, 32'h42);
        #2 chk("s6_r7_bubble", bus.hazard, 1'b1);
        tick();
        bus.rsin = 5'd8;
        #2 chk("s6_reload_r8", bus.hazard, 1'b1);
        bus.rsin = 5'd7;
        #1 chk("s6_r7_free", bus.hazard, 1'b0);
        chk("s6_r7_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("s6_user_out", bus.immout, 32'h42);
        chk("s6_user_rs", bus.rsout, 5'd7);
        tick();
        tick();

        // ---------------- 4: flush with both entries full
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b000, 1'b1, 5'd1, 5'd10, 5'd0, 32'h50);
        tick();
        drive(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'h51);
        tick();
        drive(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'h52);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #2 chk("s4_flush_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        drive(1'b1, 3'b010, 1'b0, 5'd10, 5'd3, 5'd4, 32'h53);
        #2 chk("s4_out_cleared", bus.out_valid, 1'b0);
        chk("s4_ldcnt_cleared", bus.hazard, 1'b0);
        chk("s4_skid_cleared", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("s4_next_is_new", bus.immout, 32'h53);
        tick();

        // ---------------- 5: asynchronous reset mid-cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b011, 1'b0, 5'd1, 5'd2, 5'd3, 32'h60);
        tick();
        bus.in_valid = 1'b0;
        chk("s5_pre_valid", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_valid", bus.out_valid, 1'b0);
        chk("s5_async_imm", bus.immout, 32'd0);
        chk("s5_async_rsdata", bus.rsdataout, 32'd0);
        chk("s5_async_aluop", bus.aluopout, 3'd0);
        sb_q.delete();
        #4 rst_n = 1'b1;
        tick();
        chk("s5_post_empty", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b100, 1'b0, 5'd1, 5'd2, 5'd3, 32'h61);
        #2 chk("s5_post_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("s5_resume", bus.immout, 32'h61);
        tick();
        chk("final_sb_empty", 128'(sb_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
